fp_div_issue: RTL and testbench
===============================

Name: fp_div_issue

Overview:
- Sequential issue/writeback stage directly upstream and downstream of the combinational fp_div datapath in the FPU.
- Accepts a divide request from decode/issue with a valid/ready handshake and resolves the rounding mode.
- Holds the operands stable on fp_div inputs for a fixed multicycle window, then captures Result/OverFlow.
- Presents the captured response to writeback with valid/ready backpressure; supports pipeline flush.

Parameters:
- WAIT_CYCLES, 4, clock edges operands are held on fp_div before the result is sampled (>=1; matches the multicycle path constraint).
- TAG_W, 5, width of destination register tag carried with the request.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- flush  input  1  kill any in-flight or pending operation
- req_valid  input  1  request valid
- req_ready  output  1  stage can accept a request
- req_a  input  32  dividend, IEEE-754 single
- req_b  input  32  divisor, IEEE-754 single
- req_rm  input  3  instruction rounding mode; 3'b111 = dynamic
- req_tag  input  TAG_W  destination register tag
- frm  input  3  fcsr.frm, used when req_rm = 3'b111
- div_a  output  32  to fp_div Num_A
- div_b  output  32  to fp_div Num_B
- div_rm  output  3  to fp_div R_M (resolved)
- div_result  input  32  from fp_div Result
- div_overflow  input  1  from fp_div OverFlow
- rsp_valid  output  1  response valid
- rsp_ready  input  1  writeback accepts response
- rsp_result  output  32  quotient
- rsp_overflow  output  1  overflow flag
- rsp_illegal  output  1  resolved rounding mode was reserved (5/6/7)
- rsp_tag  output  TAG_W  tag of response
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, WAIT, DONE. Reset: state = IDLE; all registered outputs (div_a, div_b, div_rm, rsp_result, rsp_overflow, rsp_illegal, rsp_tag, rsp_valid, count) = 0.
- req_ready = (state == IDLE) && !rst && !flush. busy = (state != IDLE).
- Rounding-mode resolution: rm_res = (req_rm == 3'b111) ? frm : req_rm. The mode is illegal if rm_res is in {5, 6, 7}.
- IDLE, on accept (req_valid && req_ready):
  - Latch req_tag and rm_res.
  - Legal rm: latch req_a and req_b into div_a and div_b; count = WAIT_CYCLES-1; go to WAIT.
  - Illegal rm: div_a and div_b are not updated; rsp_result = 32'h7FC00000; rsp_overflow = 0; rsp_illegal = 1; go to DONE. rsp_valid is high after 1 edge.
- WAIT:
  - div_a, div_b and div_rm are held constant throughout.
  - Each edge with count != 0: count decrements.
  - Edge with count == 0: rsp_result = div_result, rsp_overflow = div_overflow, rsp_illegal = 0; go to DONE.
  - Net latency: rsp_valid rises exactly WAIT_CYCLES edges after the accept edge.
- DONE:
  - rsp_valid = 1; rsp_* are held stable while rsp_ready = 0.
  - On rsp_ready: go to IDLE, rsp_valid = 0 at the next edge.
- Flush: a synchronous edge with flush = 1 forces IDLE and clears rsp_valid and count. The flushed response is never presented.
  - Flush has priority over accept and over the rsp handshake in the same cycle.
  - div_a and div_b keep their old values, because fp_div is combinational and the values are harmless.
- Reset mid-operation behaves identically to flush; in addition, all registered outputs are zeroed.
- rsp_* and div_* are driven only from registers; there is no combinational path from req_* to rsp_*.

Optional Feature:
- Macro: FP_DIV_ISSUE_PIPE_EN.
- Defined:
  - req_ready is also high in DONE when rsp_ready = 1 (and !flush, !rst).
  - A simultaneous response handshake and new accept go directly to WAIT (or to DONE for an illegal rm), with no IDLE bubble.
  - Throughput: one divide per WAIT_CYCLES+1 edges minus the bubble, i.e. one divide per WAIT_CYCLES edges with legal rm.
- Undefined: req_ready is high only in IDLE; back-to-back requests incur one idle cycle.

Test Plan:
- Basic divide: req_a=0x40C00000 (6.0), req_b=0x40000000 (2.0), req_rm=0, rsp_ready=1 -> rsp_valid high 4 edges after accept; rsp_result=0x40400000, rsp_overflow=0, rsp_illegal=0, rsp_tag echoes req_tag=5'd9; busy high in between.
- Backpressure: as basic, but hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_valid and rsp_result stay constant; req_ready=0 throughout; IDLE one edge after rsp_ready=1.
- Dynamic rounding: req_rm=3'b111, frm=3'b001 -> div_rm=3'b001 throughout WAIT. Then req_rm=3'b111, frm=3'b101 -> rsp_valid after 1 edge with rsp_illegal=1 and rsp_result=0x7FC00000.
- Flush mid-WAIT: accept, assert flush on the 2nd WAIT cycle together with req_valid=1 -> no accept that cycle; state IDLE next edge; rsp_valid never rises; next request completes normally.
- Reset mid-DONE: response pending with rsp_ready=0, assert rst for 1 cycle -> all outputs 0 and req_ready=0 during rst; req_ready=1 on the first cycle after rst drops.
- FP_DIV_ISSUE_PIPE_EN: two requests (6.0/2.0, then 1.0/4.0 = 0x3F800000/0x40800000) with req_valid and rsp_ready held high -> second accepted on the first response's handshake edge. Second response 0x3E800000 arrives 4 edges later. Without the macro it arrives 5 edges later.

Source files
------------

// File: rtl/fp_div_issue.sv
// fp_div_issue: issue/writeback wrapper holding operands on a combinational fp_div for a multicycle window.
// Define FP_DIV_ISSUE_PIPE_EN to accept a new request on the response handshake cycle.
module fp_div_issue #(
  parameter int WAIT_CYCLES = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       frm,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic [2:0]       div_rm,
  input  logic [31:0]      div_result,
  input  logic             div_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [2:0] rm_res;
  logic illegal, accept;
  assign rm_res = (req_rm == 3'b111) ? frm : req_rm;
  assign illegal = rm_res >= 3'd5;
`ifdef FP_DIV_ISSUE_PIPE_EN
  assign req_ready = !rst && !flush && (state == IDLE || (state == DONE && rsp_ready));
`else
  assign req_ready = !rst && !flush && state == IDLE;
`endif
  assign accept = req_valid && req_ready;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (accept) state_n = illegal ? DONE : WAIT;
    else if (state == WAIT && count == '0) state_n = DONE;
    else if (state == DONE && rsp_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      div_a <= '0;
      div_b <= '0;
      div_rm <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_overflow <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_tag <= '0;
    end else begin
      state <= state_n;
      rsp_valid <= state_n == DONE;
      if (flush) count <= '0;
      else if (accept) begin
        rsp_tag <= req_tag;
        div_rm <= rm_res;
        if (illegal) begin
          rsp_result <= 32'h7FC00000;
          rsp_overflow <= 1'b0;
          rsp_illegal <= 1'b1;
        end else begin
          div_a <= req_a;
          div_b <= req_b;
          count <= CW'(WAIT_CYCLES - 1);
        end
      end else if (state == WAIT) begin
        if (count != '0) count <= count - 1'b1;
        else begin
          rsp_result <= div_result;
          rsp_overflow <= div_overflow;
          rsp_illegal <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_div_issue.sv
// tb_fp_div_issue: directed bench with a timestamp-based transaction model and per-cycle compare.
module tb_fp_div_issue;
  localparam int W = 4;
  localparam int TW = 5;
`ifdef FP_DIV_ISSUE_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  logic clk = 0, rst = 1, flush = 0, req_valid = 0, rsp_ready = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic [2:0] req_rm = 0, frm = 0;
  logic [TW-1:0] req_tag = 0;
  logic req_ready, rsp_valid, rsp_overflow, rsp_illegal, busy;
  logic [31:0] div_a, div_b, rsp_result;
  logic [2:0] div_rm;
  logic [TW-1:0] rsp_tag;
  logic [32:0] fd;
  int errors = 0, checks = 0, n;
  bit started = 0;

  fp_div_issue #(.WAIT_CYCLES(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_tag(req_tag), .frm(frm),
    .div_a(div_a), .div_b(div_b), .div_rm(div_rm), .div_result(fd[31:0]), .div_overflow(fd[32]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational divider: known quotients, anything else is a^b.
  function automatic logic [32:0] fdiv(logic [31:0] a, logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return {1'b0, 32'h40400000};
    if (a == 32'h3F800000 && b == 32'h40800000) return {1'b0, 32'h3E800000};
    if (a == 32'h7F7FFFFF && b == 32'h00800000) return {1'b1, 32'h7F800000};
    return {1'b0, a ^ b};
  endfunction
  assign fd = fdiv(div_a, div_b);

  // Model: an operation is pending until its due edge, then presented until handshaken.
  int cyc = 0, m_due = 0;
  bit m_pend = 0, m_pres = 0, m_ovf = 0, m_ill = 0;
  logic [31:0] m_a = 0, m_b = 0, m_res = 0;
  logic [2:0] m_rm = 0;
  logic [TW-1:0] m_tag = 0;
  logic exp_ready;
  assign exp_ready = !rst && !flush && ((!m_pend && !m_pres) || (PIPE && m_pres && rsp_ready));

  always @(posedge clk) begin : model
    bit acc, ill, pend, pres, ovf, il;
    logic [2:0] rm;
    logic [31:0] r;
    acc = req_valid && exp_ready;
    rm = (req_rm == 3'b111) ? frm : req_rm;
    ill = rm > 3'd4;
    pend = m_pend; pres = m_pres; r = m_res; ovf = m_ovf; il = m_ill;
    cyc <= cyc + 1;
    if (rst) begin
      m_pend <= 0; m_pres <= 0; m_a <= 0; m_b <= 0; m_rm <= 0;
      m_res <= 0; m_ovf <= 0; m_ill <= 0; m_tag <= 0;
    end else if (flush) begin
      m_pend <= 0; m_pres <= 0;
    end else begin
      if (pres && rsp_ready) pres = 0;
      if (pend && cyc + 1 == m_due) begin
        pend = 0; pres = 1; {ovf, r} = fdiv(m_a, m_b); il = 0;
      end
      if (acc) begin
        m_tag <= req_tag; m_rm <= rm;
        if (ill) begin
          pres = 1; r = 32'h7FC00000; ovf = 0; il = 1;
        end else begin
          pend = 1; m_due <= cyc + 1 + W; m_a <= req_a; m_b <= req_b;
        end
      end
      m_pend <= pend; m_pres <= pres; m_res <= r; m_ovf <= ovf; m_ill <= il;
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (started) begin
    chk("rsp_valid", 32'(rsp_valid), 32'(m_pres));
    chk("busy", 32'(busy), 32'(m_pend || m_pres));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("div_a", div_a, m_a);
    chk("div_b", div_b, m_b);
    chk("div_rm", 32'(div_rm), 32'(m_rm));
    if (m_pres) begin
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_overflow", 32'(rsp_overflow), 32'(m_ovf));
      chk("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
      chk("rsp_tag", 32'(rsp_tag), 32'(m_tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] a, logic [31:0] b, logic [2:0] rm, logic [2:0] f, logic [TW-1:0] t);
    req_a = a; req_b = b; req_rm = rm; frm = f; req_tag = t; req_valid = 1;
    step();
    req_valid = 0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!rsp_valid && k < 20) begin
      step();
      k++;
    end
    if (!rsp_valid) begin
      errors++;
      $display("FAIL wait_valid: timeout after %0d cycles", k);
    end
  endtask

  initial begin
    step();
    step();
    started = 1;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 1);
    // basic 6/2
    rsp_ready = 1;
    send(32'h40C00000, 32'h40000000, 3'd0, 3'd0, 5'd9);
    wait_valid(n);
    chk("lat_basic", n, 4);
    chk("res_basic", rsp_result, 32'h40400000);
    chk("tag_basic", 32'(rsp_tag), 9);
    chk("ovf_basic", 32'(rsp_overflow), 0);
    step();
    chk("idle_basic", 32'(busy), 0);
    // overflow passthrough
    send(32'h7F7FFFFF, 32'h00800000, 3'd3, 3'd0, 5'd7);
    wait_valid(n);
    chk("ovf_flag", 32'(rsp_overflow), 1);
    chk("ovf_res", rsp_result, 32'h7F800000);
    step();
    // backpressure
    rsp_ready = 0;
    send(32'h40C00000, 32'h40000000, 3'd0, 3'd0, 5'd10);
    wait_valid(n);
    repeat (3) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_result", rsp_result, 32'h40400000);
      chk("bp_ready", 32'(req_ready), 0);
      step();
    end
    rsp_ready = 1;
    step();
    chk("bp_idle", 32'(busy), 0);
    chk("bp_drop", 32'(rsp_valid), 0);
    // dynamic rounding, legal then reserved
    send(32'h3F800000, 32'h40800000, 3'b111, 3'b001, 5'd11);
    repeat (3) begin
      chk("dyn_rm", 32'(div_rm), 1);
      step();
    end
    wait_valid(n);
    chk("dyn_res", rsp_result, 32'h3E800000);
    step();
    send(32'h40C00000, 32'h40000000, 3'b111, 3'b101, 5'd12);
    wait_valid(n);
    chk("ill_lat", n, 0);
    chk("ill_flag", 32'(rsp_illegal), 1);
    chk("ill_res", rsp_result, 32'h7FC00000);
    chk("ill_div_a", div_a, 32'h3F800000);
    step();
    // flush mid-WAIT with a competing request
    send(32'h40C00000, 32'h40000000, 3'd0, 3'd0, 5'd13);
    step();
    flush = 1; req_valid = 1; req_tag = 5'd14;
    #1;
    chk("flush_ready", 32'(req_ready), 0);
    step();
    flush = 0; req_valid = 0;
    chk("flush_idle", 32'(busy), 0);
    repeat (6) begin
      chk("flush_novalid", 32'(rsp_valid), 0);
      step();
    end
    send(32'h3F800000, 32'h40800000, 3'd0, 3'd0, 5'd15);
    wait_valid(n);
    chk("post_flush_lat", n, 4);
    chk("post_flush_tag", 32'(rsp_tag), 15);
    step();
    // reset while a response is pending
    rsp_ready = 0;
    send(32'h40C00000, 32'h40000000, 3'd1, 3'd0, 5'd16);
    wait_valid(n);
    rst = 1;
    #1;
    chk("rstm_ready", 32'(req_ready), 0);
    step();
    chk("rstm_valid", 32'(rsp_valid), 0);
    chk("rstm_result", rsp_result, 0);
    chk("rstm_div_a", div_a, 0);
    chk("rstm_div_rm", 32'(div_rm), 0);
    chk("rstm_tag", 32'(rsp_tag), 0);
    chk("rstm_busy", 32'(busy), 0);
    rst = 0;
    #1;
    chk("rstm_ready_after", 32'(req_ready), 1);
    rsp_ready = 1;
    // back-to-back
    send(32'h40C00000, 32'h40000000, 3'd0, 3'd0, 5'd1);
    req_a = 32'h3F800000; req_b = 32'h40800000; req_tag = 5'd2; req_valid = 1;
    wait_valid(n);
    chk("b2b_first", rsp_result, 32'h40400000);
    n = 0;
    do begin
      step();
      n++;
    end while (!(rsp_valid && rsp_tag == 5'd2) && n < 20);
    req_valid = 0;
    chk("b2b_gap", n, PIPE ? 5 : 6);
    chk("b2b_second", rsp_result, 32'h3E800000);
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
